// File: rtl/ysyx_25040105_lsu_pkg.sv
// Shared constants, FSM state type and the alignment rule for the load/store unit.
package ysyx_25040105_lsu_pkg;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;
    localparam logic [1:0] SZ_X = 2'b11;

    localparam int OP_STORE = 3;
    localparam int OP_UNS   = 2;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } lsu_state_e;

    // An illegal size is treated like a misaligned access: it never reaches memory.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        logic mis;
        mis = 1'b0;
        case (size)
            SZ_H:    mis = addr_lo[0];
            SZ_W:    mis = (addr_lo != 2'b00);
            SZ_X:    mis = 1'b1;
            default: mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/ysyx_25040105_lsu_if.sv
// Upstream, writeback and memory-port signals of the load/store unit.
// Each valid/ready pair transfers on a rising edge where both are high; the sender holds its payload stable while valid is high and ready is low.
interface ysyx_25040105_lsu_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_addr;
    logic [31:0] in_wdata;
    logic [3:0]  in_op;
    logic [4:0]  in_rd;

    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_rdata;
    logic [4:0]  out_rd;
    logic        out_wen;
    logic        out_err;

    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_addr;
    logic        mem_wen;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_resp_valid;
    logic [31:0] mem_rdata;
    logic        mem_resp_err;

    modport lsu (
        input  in_valid, in_addr, in_wdata, in_op, in_rd,
        output in_ready,
        output out_valid, out_rdata, out_rd, out_wen, out_err,
        input  out_ready,
        output mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wstrb,
        input  mem_req_ready, mem_resp_valid, mem_rdata, mem_resp_err
    );

    modport env (
        output in_valid, in_addr, in_wdata, in_op, in_rd,
        input  in_ready,
        input  out_valid, out_rdata, out_rd, out_wen, out_err,
        output out_ready,
        input  mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wstrb,
        output mem_req_ready, mem_resp_valid, mem_rdata, mem_resp_err
    );
endinterface

// File: rtl/ysyx_25040105_lsu_align.sv
// Combinational lane logic: store data/strobe replication and load extract/extend.
module ysyx_25040105_lsu_align
    import ysyx_25040105_lsu_pkg::*;
(
    input  logic [1:0]  st_size,
    input  logic [1:0]  st_addr_lo,
    input  logic [31:0] st_wdata_in,
    output logic [31:0] st_wdata,
    output logic [3:0]  st_wstrb,
    input  logic [1:0]  ld_size,
    input  logic        ld_uns,
    input  logic [1:0]  ld_addr_lo,
    input  logic [31:0] ld_rdata,
    output logic [31:0] ld_data
);
    logic [31:0] shifted;

    always_comb begin
        st_wdata = st_wdata_in;
        st_wstrb = 4'b1111;
        case (st_size)
            SZ_B: begin
                st_wdata = {4{st_wdata_in[7:0]}};
                st_wstrb = 4'b0001 << st_addr_lo;
            end
            SZ_H: begin
                st_wdata = {2{st_wdata_in[15:0]}};
                st_wstrb = 4'b0011 << st_addr_lo;
            end
            SZ_W:    st_wstrb = 4'b1111;
            default: st_wstrb = 4'b0000;
        endcase
    end

    always_comb begin
        shifted = ld_rdata >> {ld_addr_lo, 3'b000};
        ld_data = shifted;
        case (ld_size)
            SZ_B: ld_data = ld_uns ? {24'd0, shifted[7:0]} : {{24{shifted[7]}}, shifted[7:0]};
            SZ_H: ld_data = ld_uns ? {16'd0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
            default: ld_data = shifted;
        endcase
    end
endmodule

// File: rtl/ysyx_25040105_lsu.sv
// Load/store unit: one aligned access at a time between execute and writeback.
// Every output is either a flop or a decode of the state register.
module ysyx_25040105_lsu
    import ysyx_25040105_lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst_n,
    ysyx_25040105_lsu_if.lsu bus,
    output lsu_state_e       dbg_state
);
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

    lsu_state_e  state_q, state_d;
    logic [1:0]  addr_lo_q, addr_lo_d;
    logic [3:0]  op_q, op_d;
    logic [15:0] timer_q, timer_d;
    logic [31:0] out_rdata_q, out_rdata_d;
    logic [4:0]  out_rd_q, out_rd_d;
    logic        out_wen_q, out_wen_d;
    logic        out_err_q, out_err_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic        mem_wen_q, mem_wen_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [3:0]  mem_wstrb_q, mem_wstrb_d;

    logic [31:0] st_wdata, ld_data;
    logic [3:0]  st_wstrb;
    logic        is_load;

    // Store lanes come from the incoming request; load extraction from the latched one.
    ysyx_25040105_lsu_align u_align (
        .st_size    (bus.in_op[1:0]),
        .st_addr_lo (bus.in_addr[1:0]),
        .st_wdata_in(bus.in_wdata),
        .st_wdata   (st_wdata),
        .st_wstrb   (st_wstrb),
        .ld_size    (op_q[1:0]),
        .ld_uns     (op_q[OP_UNS]),
        .ld_addr_lo (addr_lo_q),
        .ld_rdata   (bus.mem_rdata),
        .ld_data    (ld_data)
    );

    assign is_load = ~op_q[OP_STORE];

    always_comb begin
        state_d     = state_q;
        addr_lo_d   = addr_lo_q;
        op_d        = op_q;
        timer_d     = timer_q;
        out_rdata_d = out_rdata_q;
        out_rd_d    = out_rd_q;
        out_wen_d   = out_wen_q;
        out_err_d   = out_err_q;
        mem_addr_d  = mem_addr_q;
        mem_wen_d   = mem_wen_q;
        mem_wdata_d = mem_wdata_q;
        mem_wstrb_d = mem_wstrb_q;
        case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    addr_lo_d   = bus.in_addr[1:0];
                    op_d        = bus.in_op;
                    out_rd_d    = bus.in_rd;
                    mem_addr_d  = {bus.in_addr[31:2], 2'b00};
                    mem_wen_d   = bus.in_op[OP_STORE];
                    mem_wdata_d = st_wdata;
                    mem_wstrb_d = bus.in_op[OP_STORE] ? st_wstrb : 4'b0000;
                    if (is_misaligned(bus.in_op[1:0], bus.in_addr[1:0])) begin
                        state_d     = S_DONE;
                        out_err_d   = 1'b1;
                        out_wen_d   = 1'b0;
                        out_rdata_d = 32'd0;
                    end else begin
                        state_d = S_REQ;
                    end
                end
            end
            S_REQ: begin
                if (bus.mem_req_ready) begin
                    state_d = S_WAIT;
                    timer_d = 16'd0;
                end
            end
            S_WAIT: begin
                timer_d = timer_q + 16'd1;
                // A response on the last allowed cycle beats the timeout.
                if (bus.mem_resp_valid) begin
                    state_d     = S_DONE;
                    out_err_d   = bus.mem_resp_err;
                    out_rdata_d = (is_load && !bus.mem_resp_err) ? ld_data : 32'd0;
                    out_wen_d   = is_load && !bus.mem_resp_err && (out_rd_q != 5'd0);
                end else if (timer_q == TMO_LAST) begin
                    state_d     = S_DONE;
                    out_err_d   = 1'b1;
                    out_rdata_d = 32'd0;
                    out_wen_d   = 1'b0;
                end
            end
            S_DONE: begin
                if (bus.out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            addr_lo_q   <= 2'd0;
            op_q        <= 4'd0;
            timer_q     <= 16'd0;
            out_rdata_q <= 32'd0;
            out_rd_q    <= 5'd0;
            out_wen_q   <= 1'b0;
            out_err_q   <= 1'b0;
            mem_addr_q  <= 32'd0;
            mem_wen_q   <= 1'b0;
            mem_wdata_q <= 32'd0;
            mem_wstrb_q <= 4'd0;
        end else begin
            state_q     <= state_d;
            addr_lo_q   <= addr_lo_d;
            op_q        <= op_d;
            timer_q     <= timer_d;
            out_rdata_q <= out_rdata_d;
            out_rd_q    <= out_rd_d;
            out_wen_q   <= out_wen_d;
            out_err_q   <= out_err_d;
            mem_addr_q  <= mem_addr_d;
            mem_wen_q   <= mem_wen_d;
            mem_wdata_q <= mem_wdata_d;
            mem_wstrb_q <= mem_wstrb_d;
        end
    end

    assign bus.in_ready      = (state_q == S_IDLE);
    assign bus.out_valid     = (state_q == S_DONE);
    assign bus.mem_req_valid = (state_q == S_REQ);
    assign bus.out_rdata     = out_rdata_q;
    assign bus.out_rd        = out_rd_q;
    assign bus.out_wen       = out_wen_q;
    assign bus.out_err       = out_err_q;
    assign bus.mem_addr      = mem_addr_q;
    assign bus.mem_wen       = mem_wen_q;
    assign bus.mem_wdata     = mem_wdata_q;
    assign bus.mem_wstrb     = mem_wstrb_q;
    assign dbg_state         = state_q;
endmodule

// File: tb/tb_ysyx_25040105_lsu.sv
// Bench for the load/store unit: directed cases plus randomized accesses against a behavioural model.
module tb_ysyx_25040105_lsu;
    import ysyx_25040105_lsu_pkg::*;

    localparam int TB_TIMEOUT = 4;
    localparam int NO_RESP    = 99;

    logic       clk = 1'b0;
    logic       rst_n;
    lsu_state_e dbg_state;
    int         n_checks = 0;
    int         n_pass   = 0;

    ysyx_25040105_lsu_if bus ();

    ysyx_25040105_lsu #(.TIMEOUT(TB_TIMEOUT)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          lat;
        logic        req;
        logic [31:0] maddr;
        logic [31:0] mwdata;
        logic [3:0]  mstrb;
        logic        mwen;
        logic [31:0] rdata;
        logic        err;
        logic        wen;
    } exp_t;

    typedef struct {
        int          lat;
        logic        req;
        logic [31:0] maddr;
        logic [31:0] mwdata;
        logic [3:0]  mstrb;
        logic        mwen;
        logic [31:0] rdata;
        logic        err;
        logic        wen;
        logic [4:0]  rd;
        logic        stable;
        logic        ready_before;
        logic        ready_after;
    } obs_t;

    // Reference: derived from the access rules with plain arithmetic.
    function automatic exp_t model(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] op,
                                   input logic [4:0] rd, input int req_delay, input int resp_delay,
                                   input logic [31:0] rdata, input logic rerr);
        exp_t        e;
        int          size;
        int          lane;
        logic        store;
        logic        mis;
        logic        tmo;
        logic [31:0] v;
        size  = int'(op[1:0]);
        lane  = int'(addr % 4);
        store = op[3];
        mis   = (size == 3) || (size == 1 && lane % 2 != 0) || (size == 2 && lane != 0);
        tmo   = resp_delay >= TB_TIMEOUT;
        e.req   = !mis;
        e.lat   = mis ? 1 : 3 + req_delay + (tmo ? TB_TIMEOUT - 1 : resp_delay);
        e.maddr = addr - 32'(lane);
        e.mwen  = store;
        e.mwdata = wdata;
        e.mstrb  = 4'd15;
        if (size == 0) begin
            e.mwdata = (wdata % 256) * 32'h0101_0101;
            e.mstrb  = 4'(1 << lane);
        end else if (size == 1) begin
            e.mwdata = (wdata % 65536) * 32'h0001_0001;
            e.mstrb  = 4'(3 << lane);
        end
        if (!store) e.mstrb = 4'd0;
        e.err = mis || tmo || rerr;
        v = rdata >> (8 * lane);
        if (size == 0) begin
            v = v % 256;
            if (!op[2] && v >= 128) v = v - 256;
        end else if (size == 1) begin
            v = v % 65536;
            if (!op[2] && v >= 32768) v = v - 65536;
        end else begin
            v = rdata;
        end
        e.rdata = (!store && !e.err) ? v : 32'd0;
        e.wen   = !store && !e.err && (rd != 5'd0);
        return e;
    endfunction

    // Drives one access from a negedge and returns at a negedge with in_ready expected high.
    task automatic do_access(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] op,
                             input logic [4:0] rd, input int req_delay, input int resp_delay,
                             input logic [31:0] rdata, input logic rerr, input int stall,
                             input logic stray, output obs_t o);
        int   cyc;
        int   wcnt;
        int   rcnt;
        logic in_wait;
        o = '{default: 0};
        o.lat = -1;
        o.stable = 1'b1;
        o.ready_before = bus.in_ready;
        bus.in_valid = 1'b1;
        bus.in_addr  = addr;
        bus.in_wdata = wdata;
        bus.in_op    = op;
        bus.in_rd    = rd;
        cyc = 0; wcnt = 0; rcnt = 0; in_wait = 1'b0;
        while (cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin
                bus.in_valid = 1'b0;
                bus.in_addr  = $urandom;
                bus.in_wdata = $urandom;
                bus.in_op    = 4'($urandom);
                bus.in_rd    = 5'($urandom);
            end
            bus.mem_req_ready  = 1'b0;
            bus.mem_resp_valid = 1'b0;
            bus.mem_resp_err   = 1'b0;
            bus.mem_rdata      = $urandom;
            if (bus.out_valid) break;
            if (in_wait) begin
                if (wcnt == resp_delay) begin
                    bus.mem_resp_valid = 1'b1;
                    bus.mem_rdata      = rdata;
                    bus.mem_resp_err   = rerr;
                end
                wcnt++;
            end else if (bus.mem_req_valid) begin
                o.req    = 1'b1;
                o.maddr  = bus.mem_addr;
                o.mwdata = bus.mem_wdata;
                o.mstrb  = bus.mem_wstrb;
                o.mwen   = bus.mem_wen;
                if (rcnt == req_delay) begin
                    bus.mem_req_ready = 1'b1;
                    in_wait = 1'b1;
                end else begin
                    rcnt++;
                    if (stray) begin
                        bus.mem_resp_valid = 1'b1;
                        bus.mem_resp_err   = 1'($urandom);
                    end
                end
            end
        end
        if (!bus.out_valid) return;
        o.lat   = cyc;
        o.rdata = bus.out_rdata;
        o.err   = bus.out_err;
        o.wen   = bus.out_wen;
        o.rd    = bus.out_rd;
        for (int k = 0; k < stall; k++) begin
            bus.out_ready      = 1'b0;
            bus.mem_resp_valid = 1'b1;
            bus.mem_resp_err   = 1'b1;
            bus.mem_rdata      = $urandom;
            @(negedge clk);
            if (!bus.out_valid || bus.in_ready || bus.out_rdata !== o.rdata || bus.out_err !== o.err ||
                bus.out_wen !== o.wen || bus.out_rd !== o.rd) o.stable = 1'b0;
        end
        bus.mem_resp_valid = 1'b0;
        bus.mem_resp_err   = 1'b0;
        bus.out_ready      = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        o.ready_after = bus.in_ready && !bus.out_valid;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.in_valid = 1'b0; bus.in_addr = '0; bus.in_wdata = '0; bus.in_op = '0; bus.in_rd = '0;
        bus.out_ready = 1'b0; bus.mem_req_ready = 1'b0; bus.mem_resp_valid = 1'b0;
        bus.mem_rdata = '0; bus.mem_resp_err = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++; if ({bus.in_ready, bus.out_valid, bus.mem_req_valid, bus.out_wen, bus.out_err, bus.mem_wen} !== 6'b100000)
            $display("FAIL reset_ctrl got %b want 100000", {bus.in_ready, bus.out_valid, bus.mem_req_valid, bus.out_wen, bus.out_err, bus.mem_wen}); else n_pass++;
        n_checks++; if ({bus.out_rdata, bus.out_rd, bus.mem_addr, bus.mem_wdata, bus.mem_wstrb} !== 105'd0)
            $display("FAIL reset_data got %h want 0", {bus.out_rdata, bus.out_rd, bus.mem_addr, bus.mem_wdata, bus.mem_wstrb}); else n_pass++;
        n_checks++; if (dbg_state !== S_IDLE) $display("FAIL reset_state got %0d want %0d", dbg_state, S_IDLE); else n_pass++;
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++; if ({bus.in_ready, bus.out_valid} !== 2'b10) $display("FAIL reset_release got %b want 10", {bus.in_ready, bus.out_valid}); else n_pass++;
    endtask

    task automatic test_store_byte();
        obs_t o;
        do_access(32'h8000_0003, 32'h1234_56AB, 4'b1000, 5'd7, 0, 0, 32'h0, 1'b0, 0, 1'b0, o);
        n_checks++; if (o.lat !== 3) $display("FAIL sb_lat got %0d want 3", o.lat); else n_pass++;
        n_checks++; if (o.maddr !== 32'h8000_0000) $display("FAIL sb_addr got %h want 80000000", o.maddr); else n_pass++;
        n_checks++; if (o.mwdata !== 32'hABAB_ABAB) $display("FAIL sb_wdata got %h want abababab", o.mwdata); else n_pass++;
        n_checks++; if (o.mstrb !== 4'b1000) $display("FAIL sb_wstrb got %b want 1000", o.mstrb); else n_pass++;
        n_checks++; if ({o.mwen, o.wen, o.err} !== 3'b100) $display("FAIL sb_flags got %b want 100", {o.mwen, o.wen, o.err}); else n_pass++;
    endtask

    task automatic test_load_half();
        obs_t o;
        do_access(32'h8000_0002, 32'h0, 4'b0001, 5'd9, 0, 0, 32'h8001_7FFF, 1'b0, 0, 1'b0, o);
        n_checks++; if (o.rdata !== 32'hFFFF_8001) $display("FAIL lh_data got %h want ffff8001", o.rdata); else n_pass++;
        n_checks++; if ({o.wen, o.err, o.rd} !== {2'b10, 5'd9}) $display("FAIL lh_wb got %b want 1001001", {o.wen, o.err, o.rd}); else n_pass++;
        n_checks++; if ({o.mwen, o.mstrb} !== 5'b0) $display("FAIL lh_strb got %b want 00000", {o.mwen, o.mstrb}); else n_pass++;
        do_access(32'h8000_0002, 32'h0, 4'b0101, 5'd9, 0, 0, 32'h8001_7FFF, 1'b0, 0, 1'b0, o);
        n_checks++; if (o.rdata !== 32'h0000_8001) $display("FAIL lhu_data got %h want 00008001", o.rdata); else n_pass++;
    endtask

    task automatic test_misaligned();
        obs_t o;
        do_access(32'h8000_0006, 32'h0, 4'b0010, 5'd3, 0, 0, 32'h0, 1'b0, 0, 1'b0, o);
        n_checks++; if (o.lat !== 1) $display("FAIL mis_lat got %0d want 1", o.lat); else n_pass++;
        n_checks++; if ({o.req, o.err, o.wen} !== 3'b010) $display("FAIL mis_flags got %b want 010", {o.req, o.err, o.wen}); else n_pass++;
        do_access(32'h8000_0004, 32'h0, 4'b0011, 5'd3, 0, 0, 32'h0, 1'b0, 0, 1'b0, o);
        n_checks++; if ({o.lat == 1, o.req, o.err} !== 3'b101) $display("FAIL illegal_size got %b want 101", {o.lat == 1, o.req, o.err}); else n_pass++;
    endtask

    task automatic test_timeout();
        obs_t o;
        do_access(32'h8000_0010, 32'h0, 4'b0010, 5'd4, 0, NO_RESP, 32'h0, 1'b0, 0, 1'b0, o);
        n_checks++; if (o.lat !== 2 + TB_TIMEOUT) $display("FAIL tmo_lat got %0d want %0d", o.lat, 2 + TB_TIMEOUT); else n_pass++;
        n_checks++; if ({o.err, o.wen, o.rdata} !== {2'b10, 32'd0}) $display("FAIL tmo_out got %b/%h want err=1 wen=0", {o.err, o.wen}, o.rdata); else n_pass++;
        do_access(32'h8000_0010, 32'h0, 4'b0010, 5'd4, 0, TB_TIMEOUT - 1, 32'hDEAD_BEEF, 1'b0, 0, 1'b0, o);
        n_checks++; if ({o.err, o.wen} !== 2'b01) $display("FAIL tmo_last_flags got %b want 01", {o.err, o.wen}); else n_pass++;
        n_checks++; if (o.rdata !== 32'hDEAD_BEEF) $display("FAIL tmo_last_data got %h want deadbeef", o.rdata); else n_pass++;
        do_access(32'h8000_0010, 32'h0, 4'b0010, 5'd4, 0, 1, 32'h1111_2222, 1'b1, 0, 1'b0, o);
        n_checks++; if ({o.err, o.wen, o.rdata} !== {2'b10, 32'd0}) $display("FAIL bus_err got %b/%h want err=1 wen=0 data=0", {o.err, o.wen}, o.rdata); else n_pass++;
    endtask

    task automatic test_stall();
        obs_t o;
        do_access(32'h8000_0001, 32'h0, 4'b0000, 5'd12, 1, 0, 32'h0000_8000, 1'b0, 5, 1'b1, o);
        n_checks++; if (o.rdata !== 32'hFFFF_FF80) $display("FAIL stall_data got %h want ffffff80", o.rdata); else n_pass++;
        n_checks++; if (o.stable !== 1'b1) $display("FAIL stall_stable got %b want 1", o.stable); else n_pass++;
        n_checks++; if (o.ready_after !== 1'b1) $display("FAIL stall_release got %b want 1", o.ready_after); else n_pass++;
    endtask

    task automatic test_random();
        obs_t        o;
        exp_t        e;
        logic [31:0] addr, wdata, rdata;
        logic [3:0]  op;
        logic [4:0]  rd;
        int          rq, rs, r;
        logic        rerr;
        for (int i = 0; i < 60; i++) begin
            addr  = 32'h8000_0000 | 32'($urandom_range(0, 255));
            wdata = $urandom;
            rdata = $urandom;
            op    = 4'($urandom);
            if (op[1:0] == 2'b11 && $urandom_range(0, 3) != 0) op[1:0] = 2'b10;
            rd    = 5'($urandom);
            rq    = $urandom_range(0, 2);
            r     = $urandom_range(0, 9);
            rs    = (r < 8) ? r % 4 : NO_RESP;
            rerr  = ($urandom_range(0, 7) == 0);
            e = model(addr, wdata, op, rd, rq, rs, rdata, rerr);
            do_access(addr, wdata, op, rd, rq, rs, rdata, rerr, $urandom_range(0, 2), 1'b1, o);
            n_checks++; if (o.lat !== e.lat) $display("FAIL rnd%0d_lat got %0d want %0d", i, o.lat, e.lat); else n_pass++;
            n_checks++; if ({o.err, o.wen, o.rd} !== {e.err, e.wen, rd}) $display("FAIL rnd%0d_wb got %b want %b", i, {o.err, o.wen, o.rd}, {e.err, e.wen, rd}); else n_pass++;
            n_checks++; if (o.rdata !== e.rdata) $display("FAIL rnd%0d_data got %h want %h", i, o.rdata, e.rdata); else n_pass++;
            n_checks++; if (o.req !== e.req) $display("FAIL rnd%0d_req got %b want %b", i, o.req, e.req); else n_pass++;
            n_checks++; if ({o.ready_before, o.ready_after, o.stable} !== 3'b111) $display("FAIL rnd%0d_hs got %b want 111", i, {o.ready_before, o.ready_after, o.stable}); else n_pass++;
            if (e.req) begin
                n_checks++; if ({o.maddr, o.mstrb, o.mwen} !== {e.maddr, e.mstrb, e.mwen})
                    $display("FAIL rnd%0d_mem got %h/%b/%b want %h/%b/%b", i, o.maddr, o.mstrb, o.mwen, e.maddr, e.mstrb, e.mwen); else n_pass++;
                if (op[3]) begin
                    n_checks++; if (o.mwdata !== e.mwdata) $display("FAIL rnd%0d_wdata got %h want %h", i, o.mwdata, e.mwdata); else n_pass++;
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        bus.in_valid = 1'b1; bus.in_addr = 32'h8000_0020; bus.in_op = 4'b0010; bus.in_rd = 5'd5;
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.mem_req_ready = 1'b1;
        @(negedge clk);
        bus.mem_req_ready = 1'b0;
        n_checks++; if (dbg_state !== S_WAIT) $display("FAIL mid_in_wait got %0d want %0d", dbg_state, S_WAIT); else n_pass++;
        rst_n = 1'b0;
        #1;
        n_checks++; if ({bus.in_ready, bus.out_valid, bus.mem_req_valid, bus.out_wen, bus.out_err, bus.mem_wen} !== 6'b100000)
            $display("FAIL mid_reset_ctrl got %b want 100000", {bus.in_ready, bus.out_valid, bus.mem_req_valid, bus.out_wen, bus.out_err, bus.mem_wen}); else n_pass++;
        n_checks++; if ({bus.out_rdata, bus.out_rd, bus.mem_addr, bus.mem_wdata, bus.mem_wstrb} !== 105'd0)
            $display("FAIL mid_reset_data got %h want 0", {bus.out_rdata, bus.out_rd, bus.mem_addr, bus.mem_wdata, bus.mem_wstrb}); else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        bus.mem_resp_valid = 1'b1; bus.mem_rdata = 32'hCAFE_F00D;
        @(negedge clk);
        bus.mem_resp_valid = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++; if ({bus.in_ready, bus.out_valid, bus.mem_req_valid, bus.out_rdata} !== {3'b100, 32'd0})
            $display("FAIL late_resp got %b/%h want 100/0", {bus.in_ready, bus.out_valid, bus.mem_req_valid}, bus.out_rdata); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_store_byte();
        test_load_half();
        test_misaligned();
        test_timeout();
        test_stall();
        test_random();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/ysyx_25040105_lsu.md
# ysyx_25040105_lsu

Load/store unit sitting directly downstream of the execute unit. It takes the ALU result as the effective address, plus the store data and access type, over a valid/ready handshake. It runs one aligned access at a time on a simple request/response memory port. It then returns sign- or zero-extended load data and a register-write descriptor to writeback over a second valid/ready handshake.

## Interface
- TIMEOUT, default 255: WAIT-state cycles allowed before the access is abandoned with error; legal range 1..65535.

- clk  input  1  core clock, all state on rising edge
- rst_n  input  1  reset, asynchronous assert, active-low
- in_valid  input  1  upstream presents an access
- in_ready  output  1  LSU can accept; high only in IDLE
- in_addr  input  32  effective address (ALU result)
- in_wdata  input  32  store data (rs2 value)
- in_op  input  4  [3]=store, [2]=unsigned load, [1:0]=size (00 byte, 01 half, 10 word, 11 illegal)
- in_rd  input  5  load destination register
- out_valid  output  1  result available to writeback
- out_ready  input  1  writeback accepts result
- out_rdata  output  32  extended load data; 0 for stores and errors
- out_rd  output  5  latched in_rd
- out_wen  output  1  1 iff load, no error, rd≠0
- out_err  output  1  misaligned, illegal size, bus error or timeout
- mem_req_valid  output  1  memory request
- mem_req_ready  input  1  memory accepts request
- mem_addr  output  32  {addr[31:2],2'b00}
- mem_wen  output  1  1 for store
- mem_wdata  output  32  lane-replicated store data
- mem_wstrb  output  4  byte enables; 0000 for loads
- mem_resp_valid  input  1  response/data valid
- mem_rdata  input  32  raw word read
- mem_resp_err  input  1  bus error with response

## Operation
- FSM states: IDLE, REQ, WAIT, DONE.
- IDLE: in_ready=1. A handshake (in_valid&in_ready) latches addr, wdata, op, rd. Misaligned requests go to DONE with err=1 and issue no memory access. Misaligned means: half with addr[0]=1, word with addr[1:0]≠0, or size=11. Otherwise go to REQ.
- REQ: mem_req_valid=1, memory outputs stable until mem_req_ready. Handshake -> WAIT, timer cleared.
- WAIT: mem_resp_valid -> DONE, capture formatted data, err=mem_resp_err. The timer increments each WAIT cycle. When timer reaches TIMEOUT-1 with no response -> DONE, err=1. A response in the same cycle as timeout wins (err from mem_resp_err only).
- DONE: out_valid=1, outputs held stable until out_ready. Handshake -> IDLE. There is no IDLE bypass: the next in_ready is one cycle after out handshake.
- mem_resp_valid outside WAIT is ignored; it must not alter state or outputs.
- Store lanes: byte -> wdata {4{wdata[7:0]}}, strb 0001<<addr[1:0]. Half -> {2{wdata[15:0]}}, strb 0011<<addr[1:0]. Word -> wdata, strb 1111.
- Load: shift mem_rdata right by 8*addr[1:0], then extend byte/half per op[2]. Word is passed through.

## Timing
- Reset (rst_n=0, any state): state IDLE, in_ready=1. out_valid, out_wen, out_err, mem_req_valid, mem_wen=0. out_rdata, out_rd, mem_addr, mem_wdata, mem_wstrb=0, timer=0.
- Reset mid-access abandons the outstanding transaction. A late response after reset lands in IDLE and is ignored.
- Zero-wait memory (req_ready and resp_valid same cycle as asserted): accept at cycle N, REQ N+1, WAIT N+2, out_valid N+3.
- Misaligned: accept at N, out_valid at N+1.
- All outputs are registered or decoded from state only. There is no combinational path from in_* or mem_resp_* to any output.

## Structure
- Package ysyx_25040105_lsu_pkg: size constants (SZ_B/SZ_H/SZ_W), in_op bit positions, FSM state enum.
- Sub-module ysyx_25040105_lsu_align: purely combinational. It produces store wdata/wstrb from (size, addr[1:0], wdata) and load extract/extend from (size, unsigned, addr[1:0], rdata). The top holds FSM, latches and timer.

## Test plan
- Store byte, addr 0x8000_0003, wdata 0x1234_56AB, zero-wait -> mem_addr 0x8000_0000, wdata 0xABAB_ABAB, wstrb 1000. out_valid at N+3, out_wen=0, out_err=0.
- Load half signed, addr 0x8000_0002, rdata 0x8001_7FFF -> out_rdata 0xFFFF_8001, out_wen=1, out_rd latched. Same with unsigned -> 0x0000_8001.
- Load word, addr 0x8000_0006 -> out_valid at N+1, out_err=1, out_wen=0, mem_req_valid never asserted.
- TIMEOUT=4, no response -> out_err=1 on the 4th WAIT cycle's successor. A response in the final cycle instead -> out_err=0, data returned.
- out_ready held low 5 cycles in DONE -> outputs stable, in_ready=0, stray mem_resp_valid ignored. rst_n pulsed low in WAIT -> immediate IDLE with all outputs at reset values.
